bram_frame_reader: RTL and testbench



---
 rtl/bram_frame_reader_if.sv | 34 +++
 rtl/bram_frame_reader.sv | 164 ++++++++++++++++
 tb/tb_bram_frame_reader.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/bram_frame_reader_if.sv
// Bus bundle between the frame reader and its surroundings: one read port of
// the true-dual-port block RAM plus the outgoing valid/ready word stream.
//   ram_addr/ram_en/ram_regce : RAM port controls, driven by the reader
//   ram_dout                  : RAM read data, driven by the RAM
//   m_tdata/m_tvalid/m_tlast  : stream towards the consumer
//   m_tready                  : consumer backpressure
// master = the reader, slave = RAM + consumer side.
interface bram_frame_reader_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 18
);
  logic [ADDR_WIDTH-1:0] ram_addr;
  logic                  ram_en;
  logic                  ram_regce;
  logic [DATA_WIDTH-1:0] ram_dout;
  logic [DATA_WIDTH-1:0] m_tdata;
  logic                  m_tvalid;
  logic                  m_tready;
  logic                  m_tlast;

  modport master (
    output ram_addr, ram_en, ram_regce,
    input  ram_dout,
    output m_tdata, m_tvalid, m_tlast,
    input  m_tready
  );

  modport slave (
    input  ram_addr, ram_en, ram_regce,
    output ram_dout,
    input  m_tdata, m_tvalid, m_tlast,
    output m_tready
  );
endinterface

// File: rtl/bram_frame_reader.sv
// Frame reader: fetches frame_len consecutive words from block RAM starting at
// base_addr (address wraps modulo 2^ADDR_WIDTH) and streams them out with a
// last-beat flag. Reads are only issued while in-flight reads plus buffered
// words fit in the output FIFO, so RAM latency is absorbed under backpressure
// without loss or duplication.
// Ports:
//   clka, rstb     : clock, synchronous active-high reset
//   start          : frame request, sampled only in IDLE
//   base_addr      : first word address, captured with start
//   frame_len      : word count 0..2^ADDR_WIDTH, captured with start
//   busy           : frame in progress
//   done           : one-cycle pulse at frame completion
//   bus            : RAM port + output stream (see bram_frame_reader_if)
// READ_LATENCY must be 1 or 2; FIFO_DEPTH must be at least READ_LATENCY+2
// to sustain one beat per cycle.
module bram_frame_reader #(
  parameter int ADDR_WIDTH   = 10,
  parameter int DATA_WIDTH   = 18,
  parameter int READ_LATENCY = 2,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                  clka,
  input  logic                  rstb,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   frame_len,
  output logic                  busy,
  output logic                  done,
  bram_frame_reader_if.master   bus
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FINISH} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [ADDR_WIDTH:0]     remain_q, remain_d;
  logic [READ_LATENCY-1:0] vld_pipe_q, vld_pipe_d;
  logic [READ_LATENCY-1:0] last_pipe_q, last_pipe_d;
  logic [DATA_WIDTH:0]     fifo_q [FIFO_DEPTH];
  logic [DATA_WIDTH:0]     fifo_d [FIFO_DEPTH];
  logic [PW-1:0]           wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]           rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]           count_q, count_d;

  logic [CW:0]             in_flight, credit_used;
  logic                    issue, issue_last, push, pop;
  logic [DATA_WIDTH:0]     head;

  // Credits: every read in the latency pipe already owns a FIFO slot.
  always_comb begin
    in_flight = '0;
    for (int i = 0; i < READ_LATENCY; i++)
      in_flight = in_flight + (CW+1)'(vld_pipe_q[i]);
    credit_used = in_flight + (CW+1)'(count_q);
  end

  assign head          = fifo_q[rd_ptr_q];
  assign bus.m_tvalid  = (count_q != '0);
  // Gated so that a flushed FIFO presents zeros instead of stale storage.
  assign bus.m_tdata   = bus.m_tvalid ? head[DATA_WIDTH-1:0] : '0;
  assign bus.m_tlast   = bus.m_tvalid & head[DATA_WIDTH];
  assign pop           = bus.m_tvalid & bus.m_tready;
  assign push          = vld_pipe_q[READ_LATENCY-1];

  assign bus.ram_en    = issue;
  assign bus.ram_addr  = addr_q;
  assign bus.ram_regce = 1'b1;
  assign busy          = (state_q == ISSUE) || (state_q == DRAIN);
  assign done          = (state_q == FINISH);

  // Next-state / issue logic
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    remain_d   = remain_q;
    issue      = 1'b0;
    issue_last = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (frame_len != '0) begin
            addr_d   = base_addr;
            remain_d = frame_len;
            state_d  = ISSUE;
          end else begin
            state_d  = FINISH;
          end
        end
      end
      ISSUE: begin
        if (credit_used < (CW+1)'(FIFO_DEPTH)) begin
          issue      = 1'b1;
          issue_last = (remain_q == (ADDR_WIDTH+1)'(1));
          addr_d     = addr_q + 1'b1;
          remain_d   = remain_q - 1'b1;
          if (issue_last) state_d = DRAIN;
        end
      end
      DRAIN:   if (pop && head[DATA_WIDTH]) state_d = FINISH;
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Latency pipe: the valid and last flags travel with each issued read.
  always_comb begin
    vld_pipe_d     = vld_pipe_q;
    last_pipe_d    = last_pipe_q;
    vld_pipe_d[0]  = issue;
    last_pipe_d[0] = issue_last;
    for (int i = 1; i < READ_LATENCY; i++) begin
      vld_pipe_d[i]  = vld_pipe_q[i-1];
      last_pipe_d[i] = last_pipe_q[i-1];
    end
  end

  // Show-ahead FIFO; simultaneous push and pop leave the count unchanged.
  always_comb begin
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      fifo_d[wr_ptr_q] = {last_pipe_q[READ_LATENCY-1], bus.ram_dout};
      wr_ptr_d = (wr_ptr_q == PW'(FIFO_DEPTH-1)) ? '0 : wr_ptr_q + PW'(1);
    end
    if (pop)
      rd_ptr_d = (rd_ptr_q == PW'(FIFO_DEPTH-1)) ? '0 : rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clka) begin
    if (rstb) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      remain_q    <= '0;
      vld_pipe_q  <= '0;
      last_pipe_q <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remain_q    <= remain_d;
      vld_pipe_q  <= vld_pipe_d;
      last_pipe_q <= last_pipe_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  // Storage needs no reset: occupancy is tracked by count_q alone.
  always_ff @(posedge clka) fifo_q <= fifo_d;

endmodule

// File: tb/tb_bram_frame_reader.sv
module tb_bram_frame_reader;
  localparam int AW = 10;
  localparam int DW = 18;

  logic clka = 1'b0;
  logic rstb = 1'b1;
  always #5 clka = ~clka;

  int cyc = 0;
  always @(posedge clka) cyc <= cyc + 1;

  int chk_cnt = 0, pass_cnt = 0, fail_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    chk_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // RAM contents: word i holds i+0x100, so data identifies its address.
  logic [DW-1:0] mem [1<<AW];

  // DUT A: registered-output RAM (latency 2)
  logic          a_start = 1'b0, a_tready = 1'b1, a_busy, a_done;
  logic [AW-1:0] a_base = '0;
  logic [AW:0]   a_len = '0;
  logic [DW-1:0] ra1, ra2;
  bram_frame_reader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_a ();
  bram_frame_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(2), .FIFO_DEPTH(4)) dut_a (
    .clka(clka), .rstb(rstb), .start(a_start), .base_addr(a_base), .frame_len(a_len),
    .busy(a_busy), .done(a_done), .bus(bus_a));
  always @(posedge clka) begin
    if (bus_a.ram_en) ra1 <= mem[bus_a.ram_addr];
    if (bus_a.ram_regce) ra2 <= ra1;
  end
  assign bus_a.ram_dout = ra2;
  assign bus_a.m_tready = a_tready;

  // DUT B: low-latency RAM (latency 1)
  logic          b_start = 1'b0, b_tready = 1'b1, b_busy, b_done;
  logic [AW-1:0] b_base = '0;
  logic [AW:0]   b_len = '0;
  logic [DW-1:0] rb1;
  bram_frame_reader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus_b ();
  bram_frame_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(1), .FIFO_DEPTH(4)) dut_b (
    .clka(clka), .rstb(rstb), .start(b_start), .base_addr(b_base), .frame_len(b_len),
    .busy(b_busy), .done(b_done), .bus(bus_b));
  always @(posedge clka) if (bus_b.ram_en) rb1 <= mem[bus_b.ram_addr];
  assign bus_b.ram_dout = rb1;
  assign bus_b.m_tready = b_tready;

  // Recorders
  logic [DW-1:0] a_dat[$], b_dat[$];
  logic          a_lst[$], b_lst[$];
  int            a_cyc[$], b_cyc[$];
  logic [AW-1:0] a_iss[$];
  int a_done_cnt = 0, a_done_cyc = 0, b_done_cnt = 0, b_done_cyc = 0;
  logic a_done_busy = 1'b0;
  int a_t0 = 0, b_t0 = 0;

  // Reference occupancy for A: reads in flight and words buffered.
  logic [1:0]    m_hist = '0;
  int            m_cnt = 0, m_nxt, stall_seen = 0;
  logic          prev_stall = 1'b0, prev_last;
  logic [DW-1:0] prev_data;

  always @(negedge clka) begin
    if (!rstb) begin
      if (bus_a.m_tvalid && a_tready) begin
        a_dat.push_back(bus_a.m_tdata); a_lst.push_back(bus_a.m_tlast); a_cyc.push_back(cyc);
      end
      if (bus_a.ram_en) a_iss.push_back(bus_a.ram_addr);
      if (bus_b.m_tvalid && b_tready) begin
        b_dat.push_back(bus_b.m_tdata); b_lst.push_back(bus_b.m_tlast); b_cyc.push_back(cyc);
      end
      if (bus_a.ram_en) chk("credit", int'(m_hist[0]) + int'(m_hist[1]) + m_cnt < 4, 1);
      m_nxt = m_cnt + int'(m_hist[1]) - int'(bus_a.m_tvalid && a_tready);
      if (m_hist[1]) chk("overflow", m_nxt <= 4, 1);
      if (prev_stall) begin
        chk("stall_vld", bus_a.m_tvalid, 1);
        chk("stall_data", bus_a.m_tdata, prev_data);
        chk("stall_last", bus_a.m_tlast, prev_last);
      end
      prev_stall = bus_a.m_tvalid && !a_tready;
      if (prev_stall) stall_seen++;
      prev_data = bus_a.m_tdata;
      prev_last = bus_a.m_tlast;
      m_cnt  = m_nxt;
      m_hist = {m_hist[0], bus_a.ram_en};
    end else begin
      m_cnt = 0; m_hist = '0; prev_stall = 1'b0;
    end
    if (a_done) begin a_done_cnt++; a_done_cyc = cyc; a_done_busy = a_busy; end
    if (b_done) begin b_done_cnt++; b_done_cyc = cyc; end
  end

  task automatic start_a(input logic [AW-1:0] b, input logic [AW:0] l);
    a_dat.delete(); a_lst.delete(); a_cyc.delete(); a_iss.delete(); a_done_cnt = 0;
    @(posedge clka); #1; a_start = 1'b1; a_base = b; a_len = l;
    @(posedge clka); #1; a_start = 1'b0; a_t0 = cyc;
  endtask

  task automatic wait_done_a(input int maxc);
    int n = 0;
    while (a_done_cnt == 0 && n < maxc) begin @(posedge clka); n++; end
    chk("a_done_seen", a_done_cnt != 0, 1);
    repeat (4) @(posedge clka);
    #1;
  endtask

  // Whole-frame check: order, data, address sequence, single tlast, done.
  task automatic check_frame_a(input string tag, input int base, input int len);
    int errs = 0;
    chk({tag, "_beats"}, a_dat.size(), len);
    chk({tag, "_issues"}, a_iss.size(), len);
    for (int i = 0; i < len && i < a_dat.size() && i < a_iss.size(); i++) begin
      if (a_dat[i] !== DW'(((base + i) % 1024) + 'h100)) errs++;
      if (a_lst[i] !== (i == len - 1)) errs++;
      if (a_iss[i] !== AW'((base + i) % 1024)) errs++;
    end
    chk({tag, "_seq"}, errs, 0);
    chk({tag, "_done_cnt"}, a_done_cnt, 1);
    chk({tag, "_done_busy"}, a_done_busy, 0);
    if (len > 0 && a_cyc.size() == len)
      chk({tag, "_done_lat"}, a_done_cyc - a_cyc[len-1], 1);
  endtask

  logic [15:0] lfsr = 16'hACE1;

  initial begin
    int n;
    for (int i = 0; i < (1 << AW); i++) mem[i] = DW'(i + 'h100);

    // Reset state
    repeat (3) @(posedge clka);
    @(negedge clka);
    chk("rst_busy", a_busy, 0);
    chk("rst_done", a_done, 0);
    chk("rst_en", bus_a.ram_en, 0);
    chk("rst_addr", bus_a.ram_addr, 0);
    chk("rst_vld", bus_a.m_tvalid, 0);
    chk("rst_last", bus_a.m_tlast, 0);
    chk("rst_data", bus_a.m_tdata, 0);
    chk("rst_b_vld", bus_b.m_tvalid, 0);
    @(posedge clka); #1; rstb = 1'b0;

    // Basic read
    a_tready = 1'b1;
    start_a(10'h010, 11'd8);
    @(negedge clka);
    chk("basic_first_en", bus_a.ram_en, 1);
    chk("basic_first_addr", bus_a.ram_addr, 'h010);
    chk("basic_busy", a_busy, 1);
    wait_done_a(100);
    check_frame_a("basic", 'h010, 8);
    if (a_cyc.size() == 8) begin
      chk("basic_first_beat", a_cyc[0] - a_t0, 3);
      chk("basic_contig", a_cyc[7] - a_cyc[0], 7);
    end

    // Backpressure with a pseudo-random ready pattern
    stall_seen = 0;
    start_a(10'h010, 11'd8);
    n = 0;
    while (a_done_cnt == 0 && n < 400) begin
      lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      a_tready = lfsr[0];
      @(posedge clka); #1; n++;
    end
    a_tready = 1'b1;
    chk("bp_done_seen", a_done_cnt != 0, 1);
    repeat (4) @(posedge clka);
    #1;
    check_frame_a("bp", 'h010, 8);
    chk("bp_stalled", stall_seen > 0, 1);

    // Address wrap
    start_a(10'h3FE, 11'd4);
    wait_done_a(100);
    check_frame_a("wrap", 'h3FE, 4);

    // Zero length
    start_a(10'h000, 11'd0);
    wait_done_a(20);
    check_frame_a("zero", 0, 0);
    chk("zero_done_lat", a_done_cyc - a_t0, 0);

    // Start while busy is ignored
    start_a(10'h020, 11'd16);
    repeat (3) @(posedge clka);
    #1; a_start = 1'b1; a_base = 10'h100; a_len = 11'd5;
    @(posedge clka); #1; a_start = 1'b0;
    wait_done_a(200);
    repeat (10) @(posedge clka);
    #1;
    check_frame_a("sbusy", 'h020, 16);

    // Reset in the middle of a frame
    start_a(10'h040, 11'd10);
    n = 0;
    while (a_dat.size() < 3 && n < 50) begin @(posedge clka); n++; end
    #1; rstb = 1'b1; a_tready = 1'b0;
    @(posedge clka); #1; rstb = 1'b0;
    chk("mrst_beats_at_rst", a_dat.size(), 3);
    @(negedge clka);
    chk("mrst_busy", a_busy, 0);
    chk("mrst_vld", bus_a.m_tvalid, 0);
    chk("mrst_data", bus_a.m_tdata, 0);
    chk("mrst_last", bus_a.m_tlast, 0);
    chk("mrst_en", bus_a.ram_en, 0);
    chk("mrst_addr", bus_a.ram_addr, 0);
    a_tready = 1'b1;
    repeat (8) @(posedge clka);
    #1;
    chk("mrst_no_done", a_done_cnt, 0);
    chk("mrst_no_more", a_dat.size(), 3);
    chk("mrst_idle_vld", bus_a.m_tvalid, 0);
    start_a(10'h200, 11'd2);
    wait_done_a(100);
    check_frame_a("mrst_next", 'h200, 2);

    // Full address space with wrap
    start_a(10'h3F0, 11'd1024);
    wait_done_a(1300);
    check_frame_a("full", 'h3F0, 1024);
    if (a_cyc.size() == 1024) chk("full_contig", a_cyc[1023] - a_cyc[0], 1023);

    // Latency-1 RAM
    b_dat.delete(); b_lst.delete(); b_cyc.delete(); b_done_cnt = 0;
    @(posedge clka); #1; b_start = 1'b1; b_base = 10'h005; b_len = 11'd5;
    @(posedge clka); #1; b_start = 1'b0; b_t0 = cyc;
    n = 0;
    while (b_done_cnt == 0 && n < 100) begin @(posedge clka); n++; end
    repeat (4) @(posedge clka);
    #1;
    chk("rl1_done_cnt", b_done_cnt, 1);
    chk("rl1_beats", b_dat.size(), 5);
    if (b_dat.size() == 5) begin
      n = 0;
      for (int i = 0; i < 5; i++) begin
        if (b_dat[i] !== DW'('h105 + i)) n++;
        if (b_lst[i] !== (i == 4)) n++;
      end
      chk("rl1_seq", n, 0);
      chk("rl1_first_beat", b_cyc[0] - b_t0, 2);
      chk("rl1_contig", b_cyc[4] - b_cyc[0], 4);
      chk("rl1_done_lat", b_done_cyc - b_cyc[4], 1);
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed no completion, expected finish before 1000000");
    $fatal(1, "watchdog expired");
  end
endmodule
